// File: rtl/id_issue_select_pkg.sv
// Shared decode constants, issue encodings and FSM state type for the ID issue
// stage.
package id_issue_select_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_COP0    = 6'h10;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0c;
  localparam logic [5:0] FN_BREAK   = 6'h0d;

  // Queue valid / pop-count encodings.
  localparam logic [1:0] NO_ISSUE     = 2'b00;
  localparam logic [1:0] SINGLE_ISSUE = 2'b01;
  localparam logic [1:0] DUAL_ISSUE   = 2'b11;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_SERIAL = 1'b1
  } issue_state_e;

endpackage

// File: rtl/id_issue_select_inst_class.sv
// Combinational per-slot classifier: destination, source usage, memory,
// control-transfer and serializing attributes of one MIPS instruction.
module issue_inst_class
  import id_issue_select_pkg::*;
(
  input  logic [31:0] inst,
  output logic [4:0]  dest,
  output logic        dest_v,
  output logic        rs_v,
  output logic        rt_v,
  output logic        mem,
  output logic        br,
  output logic        serial
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       is_r;
  logic       has_dest;

  assign op    = inst[31:26];
  assign funct = inst[5:0];
  assign is_r  = (op == OP_SPECIAL);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    dest     = 5'd0;
    has_dest = 1'b0;
    if (is_r) begin
      dest     = inst[15:11];
      has_dest = 1'b1;
    end else if ((op inside {[6'h08:6'h0f]}) || (op inside {[6'h20:6'h26]})) begin
      dest     = inst[20:16];
      has_dest = 1'b1;
    end else if (op == OP_JAL) begin
      dest     = 5'd31;
      has_dest = 1'b1;
    end
  end

  // $0 is hardwired, so writing it never creates a dependency.
  assign dest_v = has_dest && (dest != 5'd0);
  assign rs_v   = !((op == OP_J) || (op == OP_JAL));
  assign rt_v   = is_r || (op == OP_BEQ) || (op == OP_BNE) || (op inside {[6'h28:6'h2b]});
  assign mem    = op[5];
  assign br     = (op inside {OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ})
                  || (is_r && (funct inside {FN_JR, FN_JALR}));
  assign serial = (op == OP_COP0) || (is_r && (funct inside {FN_SYSCALL, FN_BREAK}));

endmodule

// File: rtl/id_issue_select.sv
// Dual-issue selector between the instruction queue and the ID->EXE register:
// decides the pop count each cycle and captures the issued pair.
module id_issue_select
  import id_issue_select_pkg::*;
#(
  parameter int CKPT_W = 40,
  parameter int EXC_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SBA_flush_w_i,
  input  logic                  CP0_excOccur_w_i,
  input  logic                  EXE_stall_i,
  input  logic                  EXE_serialDone_i,
  input  logic [1:0]            IQ_supplyValid_i,
  input  logic [63:0]           IQ_inst_p_i,
  input  logic [63:0]           IQ_VAddr_p_i,
  input  logic [1:0]            IQ_hasException_p_i,
  input  logic [2*EXC_W-1:0]    IQ_ExcCode_p_i,
  input  logic [1:0]            IQ_isRefill_p_i,
  input  logic [63:0]           IQ_predDest_p_i,
  input  logic [1:0]            IQ_predTake_p_i,
  input  logic [2*CKPT_W-1:0]   IQ_checkPoint_p_i,
  output logic [1:0]            ID_upDateMode_o,
  output logic [1:0]            ID_valid_o,
  output logic [63:0]           ID_inst_o,
  output logic [63:0]           ID_VAddr_o,
  output logic [63:0]           ID_predDest_o,
  output logic [1:0]            ID_hasException_o,
  output logic [1:0]            ID_isRefill_o,
  output logic [1:0]            ID_predTake_o,
  output logic [2*EXC_W-1:0]    ID_ExcCode_o,
  output logic [2*CKPT_W-1:0]   ID_checkPoint_o,
  output logic [31:0]           ID_dualCnt_o,
  output logic [31:0]           ID_singleCnt_o
);

  issue_state_e state, state_next;
  logic [1:0]   issue;
  logic         flush;
  logic         raw;

  logic [4:0] s0_dest, s1_dest;
  logic       s0_dest_v, s0_rs_v, s0_rt_v, s0_mem, s0_br, s0_serial;
  logic       s1_dest_v, s1_rs_v, s1_rt_v, s1_mem, s1_br, s1_serial;

  issue_inst_class u_class0 (
    .inst(IQ_inst_p_i[31:0]), .dest(s0_dest), .dest_v(s0_dest_v), .rs_v(s0_rs_v),
    .rt_v(s0_rt_v), .mem(s0_mem), .br(s0_br), .serial(s0_serial)
  );

  issue_inst_class u_class1 (
    .inst(IQ_inst_p_i[63:32]), .dest(s1_dest), .dest_v(s1_dest_v), .rs_v(s1_rs_v),
    .rt_v(s1_rt_v), .mem(s1_mem), .br(s1_br), .serial(s1_serial)
  );

  assign flush = SBA_flush_w_i || CP0_excOccur_w_i;
  assign raw   = s0_dest_v && ((s1_rs_v && (IQ_inst_p_i[57:53] == s0_dest)) ||
                               (s1_rt_v && (IQ_inst_p_i[52:48] == s0_dest)));

  always_comb begin
    issue = NO_ISSUE;
    if (rst || flush || EXE_stall_i || (state == ST_SERIAL)) issue = NO_ISSUE;
    else if (IQ_supplyValid_i == NO_ISSUE)                      issue = NO_ISSUE;
    else if (IQ_hasException_p_i[0] || s0_serial)               issue = SINGLE_ISSUE;
    else if (s0_br && !IQ_supplyValid_i[1])                     issue = NO_ISSUE;
    else if (!IQ_supplyValid_i[1])                              issue = SINGLE_ISSUE;
    else if (IQ_hasException_p_i[1] || s1_serial || s1_br)      issue = SINGLE_ISSUE;
    else if (raw)                                               issue = SINGLE_ISSUE;
    else if (s0_mem && s1_mem)                                  issue = SINGLE_ISSUE;
    else                                                        issue = DUAL_ISSUE;
  end

  assign ID_upDateMode_o = issue;

  always_comb begin
    state_next = state;
    case (state)
      ST_NORMAL: if ((issue != NO_ISSUE) && s0_serial)  state_next = ST_SERIAL;
      ST_SERIAL: if (EXE_serialDone_i || flush)         state_next = ST_NORMAL;
      default:                                          state_next = ST_NORMAL;
    endcase
  end

  // Payloads are reset too: downstream debug views expect zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_NORMAL;
      ID_valid_o        <= NO_ISSUE;
      ID_inst_o         <= '0;
      ID_VAddr_o        <= '0;
      ID_predDest_o     <= '0;
      ID_hasException_o <= '0;
      ID_isRefill_o     <= '0;
      ID_predTake_o     <= '0;
      ID_ExcCode_o      <= '0;
      ID_checkPoint_o   <= '0;
      ID_dualCnt_o      <= '0;
      ID_singleCnt_o    <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state <= state_next;
      if (flush) begin
        ID_valid_o <= NO_ISSUE;
      end else if (!EXE_stall_i) begin
        ID_valid_o <= issue;
        if (issue != NO_ISSUE) begin
          ID_inst_o         <= IQ_inst_p_i;
          ID_VAddr_o        <= IQ_VAddr_p_i;
          ID_predDest_o     <= IQ_predDest_p_i;
          ID_hasException_o <= IQ_hasException_p_i;
          ID_isRefill_o     <= IQ_isRefill_p_i;
          ID_predTake_o     <= IQ_predTake_p_i;
          ID_ExcCode_o      <= IQ_ExcCode_p_i;
          ID_checkPoint_o   <= IQ_checkPoint_p_i;
        end
        if (issue == DUAL_ISSUE)   ID_dualCnt_o   <= ID_dualCnt_o + 32'd1;
        if (issue == SINGLE_ISSUE) ID_singleCnt_o <= ID_singleCnt_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_id_issue_select.sv
// Directed bench for id_issue_select: pop count checked per cycle, issued
// payloads checked by a scoreboard monitor one cycle after each issue.
module tb_id_issue_select;

  localparam int CKPT_W = 40;
  localparam int EXC_W  = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                SBA_flush_w_i = 1'b0, CP0_excOccur_w_i = 1'b0;
  logic                EXE_stall_i = 1'b0, EXE_serialDone_i = 1'b0;
  logic [1:0]          IQ_supplyValid_i = 2'b00;
  logic [63:0]         IQ_inst_p_i = '0, IQ_VAddr_p_i = '0, IQ_predDest_p_i = '0;
  logic [1:0]          IQ_hasException_p_i = '0, IQ_isRefill_p_i = '0, IQ_predTake_p_i = '0;
  logic [2*EXC_W-1:0]  IQ_ExcCode_p_i = {5'h0a, 5'h04};
  logic [2*CKPT_W-1:0] IQ_checkPoint_p_i = '0;
  logic [1:0]          ID_upDateMode_o, ID_valid_o;
  logic [63:0]         ID_inst_o, ID_VAddr_o, ID_predDest_o;
  logic [1:0]          ID_hasException_o, ID_isRefill_o, ID_predTake_o;
  logic [2*EXC_W-1:0]  ID_ExcCode_o;
  logic [2*CKPT_W-1:0] ID_checkPoint_o;
  logic [31:0]         ID_dualCnt_o, ID_singleCnt_o;

  id_issue_select #(.CKPT_W(CKPT_W), .EXC_W(EXC_W)) dut (
    .clk(clk), .rst(rst), .SBA_flush_w_i(SBA_flush_w_i), .CP0_excOccur_w_i(CP0_excOccur_w_i),
    .EXE_stall_i(EXE_stall_i), .EXE_serialDone_i(EXE_serialDone_i),
    .IQ_supplyValid_i(IQ_supplyValid_i), .IQ_inst_p_i(IQ_inst_p_i), .IQ_VAddr_p_i(IQ_VAddr_p_i),
    .IQ_hasException_p_i(IQ_hasException_p_i), .IQ_ExcCode_p_i(IQ_ExcCode_p_i),
    .IQ_isRefill_p_i(IQ_isRefill_p_i), .IQ_predDest_p_i(IQ_predDest_p_i),
    .IQ_predTake_p_i(IQ_predTake_p_i), .IQ_checkPoint_p_i(IQ_checkPoint_p_i),
    .ID_upDateMode_o(ID_upDateMode_o), .ID_valid_o(ID_valid_o), .ID_inst_o(ID_inst_o),
    .ID_VAddr_o(ID_VAddr_o), .ID_predDest_o(ID_predDest_o), .ID_hasException_o(ID_hasException_o),
    .ID_isRefill_o(ID_isRefill_o), .ID_predTake_o(ID_predTake_o), .ID_ExcCode_o(ID_ExcCode_o),
    .ID_checkPoint_o(ID_checkPoint_o), .ID_dualCnt_o(ID_dualCnt_o), .ID_singleCnt_o(ID_singleCnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]         valid;
    logic [63:0]        inst;
    logic [63:0]        vaddr;
    logic [1:0]         hasexc;
    logic [2*EXC_W-1:0] exc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic        pend = 1'b0;
  int          checks = 0, errors = 0;
  int          exp_dual = 0, exp_single = 0;
  logic [31:0] pc = 32'h0000_1000;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs, rt);
    return {op, rs, rt, 16'h0003};
  endfunction
  function automatic logic [31:0] addu(input logic [4:0] d, s, t);
    return r_op(s, t, d, 6'h21);
  endfunction
  function automatic logic [31:0] subu(input logic [4:0] d, s, t);
    return r_op(s, t, d, 6'h23);
  endfunction

  localparam logic [31:0] J_I     = {6'h02, 26'h10};
  localparam logic [31:0] JAL_I   = {6'h03, 26'h20};
  localparam logic [31:0] MTC0_I  = {6'h10, 5'h04, 5'd5, 5'd12, 11'd0};
  localparam logic [31:0] SYSC_I  = {6'h00, 20'd0, 6'h0c};

  // ctl = {exc_flush, serial_done, sba_flush, stall}; one cycle of stimulus.
  task automatic step(input string name, input logic [1:0] sv, input logic [31:0] i0, i1,
                      input logic [1:0] exc, input logic [1:0] exp_mode,
                      input logic [3:0] ctl = 4'b0000);
    exp_t e;
    @(posedge clk); #1;
    IQ_supplyValid_i    = sv;
    IQ_inst_p_i         = {i1, i0};
    IQ_hasException_p_i = exc;
    IQ_VAddr_p_i        = {pc + 32'd4, pc};
    IQ_predDest_p_i     = {pc + 32'h100, pc + 32'h80};
    {CP0_excOccur_w_i, EXE_serialDone_i, SBA_flush_w_i, EXE_stall_i} = ctl;
    pc = pc + 32'd8;
    #2;
    check({name, " mode"}, ID_upDateMode_o, exp_mode);
    if (exp_mode != 2'b00) begin
      e.valid  = exp_mode;
      e.inst   = {i1, i0};
      e.vaddr  = IQ_VAddr_p_i;
      e.hasexc = exc;
      e.exc    = IQ_ExcCode_p_i;
      exp_q.push_back(e);
      if (exp_mode == 2'b11) exp_dual++;
      else exp_single++;
    end
  endtask

  // Scoreboard monitor: a nonzero pop count at this negedge means a transfer
  // whose registered result is compared at the following negedge.
  always @(negedge clk) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious issue: got valid %0h expected no transfer", ID_valid_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb valid", ID_valid_o, mon_e.valid);
        check("sb inst", ID_inst_o, mon_e.inst);
        check("sb vaddr", ID_VAddr_o, mon_e.vaddr);
        check("sb hasexc", ID_hasException_o, mon_e.hasexc);
        check("sb exccode", ID_ExcCode_o, mon_e.exc);
      end
    end
    pend = (ID_upDateMode_o != 2'b00) && !rst;
  end

  initial begin
    IQ_supplyValid_i = 2'b11;
    IQ_inst_p_i      = {addu(4, 5, 6), addu(1, 2, 3)};
    #3;
    check("reset mode", ID_upDateMode_o, 2'b00);
    check("reset valid", ID_valid_o, 2'b00);
    check("reset dualcnt", ID_dualCnt_o, 32'd0);
    check("reset inst", ID_inst_o, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    IQ_supplyValid_i = 2'b00;

    step("dual addu", 2'b11, addu(1, 2, 3), addu(4, 5, 6), 2'b00, 2'b11);
    step("idle", 2'b00, 32'd0, 32'd0, 2'b00, 2'b00);
    check("dualcnt one", ID_dualCnt_o, 32'(exp_dual));
    step("raw rs", 2'b11, addu(1, 2, 3), subu(4, 1, 6), 2'b00, 2'b01);
    step("raw pair next", 2'b11, subu(4, 1, 6), addu(7, 8, 9), 2'b00, 2'b11);
    step("beq alone", 2'b01, i_op(6'h04, 1, 2), 32'd0, 2'b00, 2'b00);
    step("beq delay", 2'b11, i_op(6'h04, 1, 2), addu(3, 4, 5), 2'b00, 2'b11);
    step("lw sw", 2'b11, i_op(6'h23, 2, 1), i_op(6'h2b, 4, 3), 2'b00, 2'b01);
    step("exc slot0", 2'b11, addu(1, 2, 3), addu(4, 5, 6), 2'b01, 2'b01);
    step("exc slot1", 2'b11, addu(1, 2, 3), addu(4, 5, 6), 2'b10, 2'b01);
    step("br slot1", 2'b11, addu(1, 2, 3), J_I, 2'b00, 2'b01);
    step("syscall slot1", 2'b11, addu(1, 2, 3), SYSC_I, 2'b00, 2'b01);
    step("raw rt", 2'b11, addu(5, 2, 3), i_op(6'h2b, 2, 5), 2'b00, 2'b01);
    step("dest zero", 2'b11, addu(0, 2, 3), subu(4, 0, 6), 2'b00, 2'b11);
    step("load use", 2'b11, i_op(6'h23, 2, 1), addu(2, 1, 3), 2'b00, 2'b01);
    step("jal ra use", 2'b11, JAL_I, addu(2, 31, 3), 2'b00, 2'b01);
    step("one mem", 2'b11, addu(1, 2, 3), i_op(6'h23, 5, 4), 2'b00, 2'b11);
    step("single valid", 2'b01, addu(1, 2, 3), 32'd0, 2'b00, 2'b01);
    step("idle2", 2'b00, 32'd0, 32'd0, 2'b00, 2'b00);

    step("mtc0", 2'b11, MTC0_I, addu(1, 2, 3), 2'b00, 2'b01);
    step("serial hold a", 2'b11, addu(1, 2, 3), addu(4, 5, 6), 2'b00, 2'b00);
    step("serial hold b", 2'b11, addu(1, 2, 3), addu(4, 5, 6), 2'b00, 2'b00);
    step("serial done", 2'b11, addu(1, 2, 3), addu(4, 5, 6), 2'b00, 2'b00, 4'b0100);
    step("after done", 2'b11, addu(1, 2, 3), addu(4, 5, 6), 2'b00, 2'b11);
    step("mtc0 with done", 2'b11, MTC0_I, addu(1, 2, 3), 2'b00, 2'b01, 4'b0100);
    step("done ignored", 2'b11, addu(1, 2, 3), addu(4, 5, 6), 2'b00, 2'b00);
    step("flush serial", 2'b11, addu(1, 2, 3), addu(4, 5, 6), 2'b00, 2'b00, 4'b0010);
    step("after flush", 2'b11, addu(1, 2, 3), addu(4, 5, 6), 2'b00, 2'b11);
    step("exc flush", 2'b11, addu(1, 2, 3), addu(4, 5, 6), 2'b00, 2'b00, 4'b1000);

    step("pre stall", 2'b11, addu(1, 2, 3), addu(4, 5, 6), 2'b00, 2'b11);
    check("exc flush clears", ID_valid_o, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step("stall", 2'b11, addu(7, 8, 9), addu(10, 11, 12), 2'b00, 2'b00, 4'b0001);
      check("stall valid hold", ID_valid_o, 2'b11);
      check("stall inst hold", ID_inst_o, {addu(4, 5, 6), addu(1, 2, 3)});
    end
    step("stall flush", 2'b11, addu(7, 8, 9), addu(10, 11, 12), 2'b00, 2'b00, 4'b0011);
    step("idle3", 2'b00, 32'd0, 32'd0, 2'b00, 2'b00);
    check("stall flush valid", ID_valid_o, 2'b00);
    check("flush payload hold", ID_inst_o, {addu(4, 5, 6), addu(1, 2, 3)});
    check("dualcnt total", ID_dualCnt_o, 32'(exp_dual));
    check("singlecnt total", ID_singleCnt_o, 32'(exp_single));

    step("burst", 2'b11, addu(1, 2, 3), addu(4, 5, 6), 2'b00, 2'b11);
    step("idle4", 2'b00, 32'd0, 32'd0, 2'b00, 2'b00);
    @(posedge clk); #1;
    rst = 1'b1;
    IQ_supplyValid_i = 2'b11;
    IQ_inst_p_i      = {addu(4, 5, 6), addu(1, 2, 3)};
    #1;
    check("async rst inst", ID_inst_o, 64'd0);
    check("async rst dualcnt", ID_dualCnt_o, 32'd0);
    check("async rst singlecnt", ID_singleCnt_o, 32'd0);
    check("async rst mode", ID_upDateMode_o, 2'b00);
    exp_dual = 0;
    exp_single = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    IQ_supplyValid_i = 2'b00;
    step("post rst dual", 2'b11, addu(1, 2, 3), addu(4, 5, 6), 2'b00, 2'b11);
    step("idle5", 2'b00, 32'd0, 32'd0, 2'b00, 2'b00);
    check("post rst dualcnt", ID_dualCnt_o, 32'(exp_dual));
    check("post rst singlecnt", ID_singleCnt_o, 32'(exp_single));

    @(posedge clk); @(posedge clk); #1;
    check("scoreboard drained", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
